// File: rtl/ysyx_ifu.sv
// ysyx_ifu -- single-outstanding instruction fetch unit.
//
// Fetches one word at a time from instruction memory and offers it to decode.
// Control-flow redirects from execute may arrive in any state; a fetch that is
// already in flight when a redirect lands is marked killed and its response is
// consumed and dropped.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   imem_req_*               request channel to memory (valid/ready, address)
//   imem_rsp_*               response channel from memory (valid/ready, data, err)
//   inst_*                   instruction channel to decode (valid/ready, word, pc, fault)
//   redirect, redirect_addr  control-flow change from execute
//
// state | meaning
// ------+-------------------------------------------------------------
// REQ   | present pc to memory (or raise a misaligned fault instead)
// WAIT  | one request outstanding, waiting for its response
// HOLD  | instruction offered to decode, held until accepted

module ysyx_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    output logic        imem_rsp_ready,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        redirect,
    input  logic [31:0] redirect_addr
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        fault_q, fault_d;

    logic        pc_aligned;

    assign pc_aligned = (pc_q[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            kill_q    <= 1'b0;
            inst_q    <= 32'h0;
            inst_pc_q <= 32'h0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            kill_q    <= kill_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        kill_d    = kill_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        fault_d   = fault_q;

        case (state_q)
            S_REQ: begin
                if (redirect) begin
                    pc_d = redirect_addr;
                    // The old-pc request still issues; its response must be dropped.
                    if (pc_aligned && imem_req_ready) begin
                        state_d = S_WAIT;
                        kill_d  = 1'b1;
                    end
                end else if (!pc_aligned) begin
                    state_d   = S_HOLD;
                    inst_d    = 32'h0;
                    inst_pc_d = pc_q;
                    fault_d   = 1'b1;
                end else if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect) begin
                    pc_d = redirect_addr;
                end
                if (imem_rsp_valid) begin
                    if (kill_q || redirect) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d    = imem_rsp_data;
                        inst_pc_d = pc_q;
                        fault_d   = imem_rsp_err;
                        state_d   = S_HOLD;
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end

            S_HOLD: begin
                // Redirect wins over the sequential pc+4 even when decode accepts.
                if (redirect) begin
                    pc_d    = redirect_addr;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Gated by rst so no request is presented while reset is held.
    assign imem_req_valid = rst && (state_q == S_REQ) && pc_aligned;
    assign imem_req_addr  = pc_q;
    assign imem_rsp_ready = (state_q == S_WAIT);
    assign inst_valid     = (state_q == S_HOLD);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign inst_fault     = fault_q;

endmodule

// File: tb/tb_ysyx_ifu.sv
module tb_ysyx_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic        imem_rsp_ready;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        redirect;
    logic [31:0] redirect_addr;

    int checks = 0;
    int errors = 0;

    ysyx_ifu #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_ready (imem_rsp_ready),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .redirect       (redirect),
        .redirect_addr  (redirect_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic rr, input logic rv, input logic [31:0] rd, input logic re,
                          input logic ir, input logic rdr, input logic [31:0] ra);
        imem_req_ready = rr;
        imem_rsp_valid = rv;
        imem_rsp_data  = rd;
        imem_rsp_err   = re;
        inst_ready     = ir;
        redirect       = rdr;
        redirect_addr  = ra;
    endtask

    typedef struct packed {
        logic        rr;
        logic        rv;
        logic [31:0] rd;
        logic        re;
        logic        ir;
        logic        rdr;
        logic [31:0] ra;
        logic        e_reqv;
        logic [31:0] e_addr;
        logic        e_rspr;
        logic        e_instv;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_fault;
    } vec_t;

    function automatic vec_t mk(logic rr, logic rv, logic [31:0] rd, logic re, logic ir,
                                logic rdr, logic [31:0] ra, logic e_reqv, logic [31:0] e_addr,
                                logic e_rspr, logic e_instv, logic [31:0] e_inst,
                                logic [31:0] e_pc, logic e_fault);
        vec_t v;
        v.rr = rr; v.rv = rv; v.rd = rd; v.re = re; v.ir = ir; v.rdr = rdr; v.ra = ra;
        v.e_reqv = e_reqv; v.e_addr = e_addr; v.e_rspr = e_rspr; v.e_instv = e_instv;
        v.e_inst = e_inst; v.e_pc = e_pc; v.e_fault = e_fault;
        return v;
    endfunction

    // Reference memory contents: a fixed scramble of the address, faults on a sparse subset.
    function automatic logic [31:0] data_of(logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    function automatic logic err_of(logic [31:0] a);
        return (a[5:2] == 4'hF);
    endfunction

    vec_t tbl[$];

    initial begin
        // random-phase model state
        logic [31:0] exp_pc;
        logic        mem_busy;
        logic [31:0] mem_addr;
        int          mem_lat;
        logic        hold_prev;
        logic [31:0] sv_inst, sv_pc;
        logic        sv_fault;
        int          delivered;
        int          nact;

        set_in(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("rst inst_valid", inst_valid, 0);
        chk("rst req_valid", imem_req_valid, 0);
        chk("rst rsp_ready", imem_rsp_ready, 0);
        chk("rst inst", inst, 0);
        chk("rst inst_pc", inst_pc, 0);
        chk("rst inst_fault", inst_fault, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // rr rv rd re ir rdr ra | reqv addr rspr instv inst pc fault
        tbl.push_back(mk(1,0,0,0,0,0,0,                          1,32'h8000_0000,0,0,0,0,0));
        tbl.push_back(mk(0,1,32'h0000_0013,0,0,0,0,              0,0,1,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,0,                          0,0,0,1,32'h0000_0013,32'h8000_0000,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,                          1,32'h8000_0004,0,0,0,0,0));
        tbl.push_back(mk(0,1,32'h0000_0093,1,0,0,0,              0,0,1,0,0,0,0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(1,0,0,0,0,0,0,                      0,0,0,1,32'h0000_0093,32'h8000_0004,1));
        tbl.push_back(mk(0,0,0,0,1,0,0,                          0,0,0,1,32'h0000_0093,32'h8000_0004,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,                          1,32'h8000_0008,0,0,0,0,0));
        tbl.push_back(mk(0,1,32'h0000_0113,0,0,0,0,              0,0,1,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,0,                          0,0,0,1,32'h0000_0113,32'h8000_0008,0));
        tbl.push_back(mk(0,0,0,0,0,1,32'h8000_0102,              1,32'h8000_000C,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,                          0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,1,32'h8000_0200,              0,0,0,1,32'h0,32'h8000_0102,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,                          1,32'h8000_0200,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,32'h8000_0100,              0,0,1,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,                          0,0,1,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,                          0,0,1,0,0,0,0));
        tbl.push_back(mk(0,1,32'hDEAD_BEEF,0,1,0,0,              0,0,1,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,1,1,32'h8000_0300,              1,32'h8000_0100,0,0,0,0,0));
        tbl.push_back(mk(0,1,32'h1111_1111,0,1,0,0,              0,0,1,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,1,0,0,                          1,32'h8000_0300,0,0,0,0,0));
        tbl.push_back(mk(0,1,32'h2222_2222,0,1,1,32'h8000_0400,  0,0,1,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,                          1,32'h8000_0400,0,0,0,0,0));
        tbl.push_back(mk(0,1,32'h3333_3333,0,0,0,0,              0,0,1,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,32'h8000_0500,              0,0,0,1,32'h3333_3333,32'h8000_0400,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,                          1,32'h8000_0500,0,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].rr, tbl[i].rv, tbl[i].rd, tbl[i].re, tbl[i].ir, tbl[i].rdr, tbl[i].ra);
            #1;
            chk($sformatf("row%0d req_valid", i), imem_req_valid, tbl[i].e_reqv);
            if (tbl[i].e_reqv) chk($sformatf("row%0d req_addr", i), imem_req_addr, tbl[i].e_addr);
            chk($sformatf("row%0d rsp_ready", i), imem_rsp_ready, tbl[i].e_rspr);
            chk($sformatf("row%0d inst_valid", i), inst_valid, tbl[i].e_instv);
            if (tbl[i].e_instv) begin
                chk($sformatf("row%0d inst", i), inst, tbl[i].e_inst);
                chk($sformatf("row%0d inst_pc", i), inst_pc, tbl[i].e_pc);
                chk($sformatf("row%0d inst_fault", i), inst_fault, tbl[i].e_fault);
            end
            @(negedge clk);
        end

        // pc wrap at the top of the address space
        set_in(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        @(negedge clk);
        set_in(1, 0, 0, 0, 0, 0, 0);
        #1 chk("wrap req_addr", imem_req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        set_in(0, 1, 32'h0000_0517, 0, 0, 0, 0);
        @(negedge clk);
        set_in(0, 0, 0, 0, 1, 0, 0);
        #1 chk("wrap inst_pc", inst_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        set_in(1, 0, 0, 0, 0, 0, 0);
        #1 chk("wrap next addr", imem_req_addr, 32'h0000_0000);
        chk("wrap next valid", imem_req_valid, 1);

        // asynchronous reset while holding an instruction, stray response afterwards
        @(negedge clk);
        set_in(0, 1, 32'h0000_0077, 0, 0, 0, 0);
        @(negedge clk);
        set_in(0, 1, 32'h0000_0099, 0, 0, 0, 0);
        #1 chk("hold before rst", inst_valid, 1);
        #1 rst = 1'b0;
        #1;
        chk("async rst inst_valid", inst_valid, 0);
        chk("async rst req_valid", imem_req_valid, 0);
        chk("async rst rsp_ready", imem_rsp_ready, 0);
        chk("async rst inst_pc", inst_pc, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post rst req_valid", imem_req_valid, 1);
        chk("post rst req_addr", imem_req_addr, RESET_PC);
        chk("post rst rsp_ready", imem_rsp_ready, 0);
        @(negedge clk);
        #1;
        chk("stray rsp ignored", inst_valid, 0);
        chk("stray rsp rsp_ready", imem_rsp_ready, 0);

        // randomized run against the instruction-stream model
        set_in(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_pc    = RESET_PC;
        mem_busy  = 1'b0;
        mem_addr  = 32'h0;
        mem_lat   = 0;
        hold_prev = 1'b0;
        sv_inst   = 32'h0;
        sv_pc     = 32'h0;
        sv_fault  = 1'b0;
        delivered = 0;

        for (int c = 0; c < 4000; c++) begin
            if (mem_busy && mem_lat == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = data_of(mem_addr);
                imem_rsp_err   = err_of(mem_addr);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
                imem_rsp_err   = 1'($urandom_range(0, 1));
                if (mem_busy) mem_lat--;
            end
            imem_req_ready = !mem_busy && ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 2) != 0);
            redirect       = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0)
                redirect_addr = 32'hFFFF_FFFC;
            else
                redirect_addr = 32'h8000_0000 | (32'($urandom_range(0, 255)) << 2)
                                | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            #1;

            if (hold_prev) begin
                chk("rand hold valid", inst_valid, 1);
                chk("rand hold inst", inst, sv_inst);
                chk("rand hold pc", inst_pc, sv_pc);
                chk("rand hold fault", inst_fault, sv_fault);
            end
            nact = int'(imem_req_valid) + int'(imem_rsp_ready) + int'(inst_valid);
            chk("rand exclusive", (nact > 1) ? 1 : 0, 0);

            if (imem_req_valid) begin
                chk("rand req_addr", imem_req_addr, exp_pc);
                chk("rand req_aligned", imem_req_addr[1:0], 0);
                if (imem_req_ready) begin
                    mem_busy = 1'b1;
                    mem_addr = imem_req_addr;
                    mem_lat  = $urandom_range(0, 3);
                end
            end
            if (imem_rsp_valid && imem_rsp_ready) mem_busy = 1'b0;

            hold_prev = 1'b0;
            if (inst_valid) begin
                if (inst_ready) begin
                    chk("rand inst_pc", inst_pc, exp_pc);
                    if (exp_pc[1:0] != 2'b00) begin
                        chk("rand mis inst", inst, 0);
                        chk("rand mis fault", inst_fault, 1);
                    end else begin
                        chk("rand inst", inst, data_of(exp_pc));
                        chk("rand fault", inst_fault, err_of(exp_pc));
                    end
                    delivered++;
                    exp_pc = exp_pc + 32'd4;
                end else if (!redirect) begin
                    hold_prev = 1'b1;
                    sv_inst   = inst;
                    sv_pc     = inst_pc;
                    sv_fault  = inst_fault;
                end
            end
            if (redirect) exp_pc = redirect_addr;
            @(negedge clk);
        end
        chk("rand progress", (delivered > 100) ? 1 : 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_ifu.md
YSYX_IFU -- requirements
Module: ysyx_IFU

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-005 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-006 SHALL have port imem_req_addr  output  32  fetch address.
REQ-007 SHALL have port imem_rsp_valid  input  1  memory response valid.
REQ-008 SHALL have port imem_rsp_ready  output  1  IFU accepts response.
REQ-009 SHALL have port imem_rsp_data  input  32  fetched instruction word.
REQ-010 SHALL have port imem_rsp_err  input  1  access fault on response.
REQ-011 SHALL have port inst_valid  output  1  instruction offered to decode.
REQ-012 SHALL have port inst_ready  input  1  decode accepts instruction.
REQ-013 SHALL have port inst  output  32  instruction word.
REQ-014 SHALL have port inst_pc  output  32  address of inst.
REQ-015 SHALL have port inst_fault  output  1  fetch fault (bus error or misaligned pc).
REQ-016 SHALL have port redirect  input  1  control-flow change from execute.
REQ-017 SHALL have port redirect_addr  input  32  new fetch target.

Function
REQ-018 SHALL implement states REQ, WAIT, HOLD, plus 32-bit pc register and 1-bit kill flag.
REQ-019 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready go to WAIT.
REQ-020 REQ with pc[1:0]!=0: no memory request; go to HOLD next cycle with inst=0, inst_fault=1, inst_pc=pc.
REQ-021 WAIT: imem_rsp_ready=1; on imem_rsp_valid latch inst=imem_rsp_data, inst_fault=imem_rsp_err, inst_pc=pc; go to HOLD.
REQ-022 HOLD: inst_valid=1; inst, inst_pc, inst_fault stable until inst_ready.
REQ-023 HOLD with inst_ready: pc <= pc+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0); go to REQ.
REQ-024 imem_rsp_ready SHALL be 0 outside WAIT; imem_req_valid SHALL be 0 outside REQ.
REQ-025 Redirect in REQ without handshake: pc <= redirect_addr, stay REQ; address changes next cycle.
REQ-026 Redirect in REQ coincident with imem_req_ready: request issues with old pc; pc <= redirect_addr; kill=1; go to WAIT.
REQ-027 Redirect in WAIT: pc <= redirect_addr; kill=1; if imem_rsp_valid same cycle, response consumed and dropped, kill cleared, go to REQ.
REQ-028 WAIT with kill=1 and imem_rsp_valid: response consumed and dropped, kill cleared, go to REQ; inst_valid never asserted for it.
REQ-029 Redirect in HOLD: held instruction discarded unless inst_ready same cycle (handshake completes); either way pc <= redirect_addr, go to REQ; redirect overrides pc+4.
REQ-030 Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD), each with immediate handshake.

Reset
REQ-031 On rst low, immediately: state=REQ, pc=RESET_PC, kill=0, inst=0, inst_pc=0, inst_fault=0; outputs inst_valid=0, imem_rsp_ready=0.
REQ-032 imem_req_valid SHALL be 0 while rst low; first request on the first posedge-sampled cycle after release.
REQ-033 Reset mid-WAIT/HOLD SHALL abandon the transaction; any later stray response SHALL be ignored (rsp_ready=0 in REQ).

Verification
REQ-034 Reset release, memory ready=1, response 1 cycle later with 32'h0000_0013 -> req_addr=32'h8000_0000, inst_valid with inst=32'h0000_0013, inst_pc=32'h8000_0000, 2 cycles after request accept.
REQ-035 Three sequential fetches, inst_ready=1 -> inst_pc 8000_0000, 8000_0004, 8000_0008; inst_ready held 0 for 5 cycles -> inst/inst_pc stable, no new request.
REQ-036 Redirect to 32'h8000_0100 while in WAIT, response arrives 3 cycles later -> response dropped, no inst_valid for it, next req_addr=32'h8000_0100.
REQ-037 Redirect to 32'h8000_0102 -> no memory request; inst_valid with inst_fault=1, inst=0, inst_pc=32'h8000_0102.
REQ-038 Response with imem_rsp_err=1 -> inst_fault=1, inst_pc correct; after acceptance pc advances by 4.
REQ-039 rst asserted during HOLD -> inst_valid=0 immediately (asynchronous); after release req_addr=RESET_PC.
